// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default sizing.
package uart_arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int DEF_N  = 4;
    localparam int DEF_DW = 8;
    localparam int DEF_GW = 2;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Upstream requester and downstream transmitter handshakes of the arbiter.
// The master modport is the arbiter side; slave is the environment side.
interface uart_tx_arbiter_if
    import uart_arb_defs::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int GW = DEF_GW
);
    logic [N-1:0]    req_en;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_done;
    logic            tx_en_sig;
    logic [DW-1:0]   tx_data;
    logic            tx_done;
    logic            busy;
    logic [GW-1:0]   grant;

    modport master (
        input  req_en, req_data, tx_done,
        output req_done, tx_en_sig, tx_data, busy, grant
    );

    modport slave (
        output req_en, req_data, tx_done,
        input  req_done, tx_en_sig, tx_data, busy, grant
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after 'last',
// wrapping modulo N.
module uart_rr_pick
    import uart_arb_defs::*;
#(
    parameter int N  = DEF_N,
    parameter int GW = DEF_GW
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] sel,
    output logic          any
);

    // Walk the distances from far to near so the nearest requester overwrites.
    always_comb begin
        sel = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) begin
                sel = GW'((int'(last) + k) % N);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte sources,
// one byte in flight at a time with a one-cycle gap after each completion.
module uart_tx_arbiter
    import uart_arb_defs::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW,
    parameter int GW = DEF_GW
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.master bus
);

    state_t        r_state;
    state_t        w_next_state;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [DW-1:0] r_tx_data;
    logic [GW-1:0] w_sel;
    logic          w_any;
    logic [N-1:0]  w_req_done;

    uart_rr_pick #(
        .N  (N),
        .GW (GW)
    ) u_pick (
        .req  (bus.req_en),
        .last (r_last),
        .sel  (w_sel),
        .any  (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next_state = ST_SEND;
            ST_SEND: if (bus.tx_done) w_next_state = ST_GAP;
            ST_GAP:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Pointer starts at N-1 so requester 0 wins first; it only advances on
    // a completed transfer, so an abandoned one leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant   <= '0;
            r_last    <= GW'(N - 1);
            r_tx_data <= '0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_grant   <= w_sel;
                r_tx_data <= bus.req_data[int'(w_sel)*DW +: DW];
            end
            if (r_state == ST_SEND && bus.tx_done) begin
                r_last <= r_grant;
            end
        end
    end

    always_comb begin
        w_req_done = '0;
        if (r_state == ST_GAP) begin
            w_req_done[r_grant] = 1'b1;
        end
    end

    assign bus.req_done  = w_req_done;
    assign bus.tx_en_sig = (r_state == ST_SEND);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.grant     = r_grant;
    assign bus.tx_data   = r_tx_data;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: randomized requests checked
// against a round-robin reference model of the arbitration rules.
module tb_uart_tx_arbiter;
    import uart_arb_defs::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int GW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N(N), .DW(DW), .GW(GW)) bus ();

    uart_tx_arbiter #(.N(N), .DW(DW), .GW(GW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        int            lat;
        logic [GW-1:0] g;
        logic [DW-1:0] d;
        bit            stable;
        logic [N-1:0]  done1;
        logic [N-1:0]  done2;
        logic          en_after;
        logic          busy1;
        logic          busy2;
    } xfer_t;

    int checks = 0;
    int failures = 0;
    int m_last = N - 1;

    // Reference: scan requesters in order of distance after the last served one.
    function automatic int model_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.req_en = '0;
        bus.req_data = '0;
        bus.tx_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_last = N - 1;
    endtask

    // Plays the transmitter: waits for tx_en_sig, holds for dur cycles,
    // pulses tx_done, and records what the arbiter showed along the way.
    task automatic run_xfer(input int dur, input logic [N-1:0] drop_mask,
                            input int release_idx, output xfer_t r);
        r.lat = 0;
        r.stable = 1'b1;
        r.done1 = 'x;
        r.done2 = 'x;
        r.en_after = 1'bx;
        r.busy1 = 1'bx;
        r.busy2 = 1'bx;
        r.g = 'x;
        r.d = 'x;
        while (r.lat < 10) begin
            @(negedge clk);
            r.lat++;
            if (bus.tx_en_sig === 1'b1) break;
        end
        if (bus.tx_en_sig !== 1'b1) begin
            r.lat = 99;
            return;
        end
        r.g = bus.grant;
        r.d = bus.tx_data;
        bus.req_en = bus.req_en & ~drop_mask;
        repeat (dur) begin
            @(negedge clk);
            if (bus.tx_en_sig !== 1'b1 || bus.tx_data !== r.d || bus.req_done !== '0) r.stable = 1'b0;
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        r.done1 = bus.req_done;
        r.en_after = bus.tx_en_sig;
        r.busy1 = bus.busy;
        if (release_idx >= 0) bus.req_en[release_idx] = 1'b0;
        @(negedge clk);
        r.done2 = bus.req_done;
        r.busy2 = bus.busy;
    endtask

    task automatic test_reset();
        bus.req_en = '0;
        bus.req_data = '0;
        bus.tx_done = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_done !== '0) begin failures++; $display("FAIL reset_req_done got=%b exp=0", bus.req_done); end
        checks++; if (bus.tx_en_sig !== 1'b0) begin failures++; $display("FAIL reset_tx_en got=%b exp=0", bus.tx_en_sig); end
        checks++; if (bus.tx_data !== '0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", bus.tx_data); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.grant !== '0) begin failures++; $display("FAIL reset_grant got=%0d exp=0", bus.grant); end
        rst_n = 1'b1;
        m_last = N - 1;
    endtask

    task automatic test_single();
        xfer_t r;
        int exp;
        apply_reset();
        bus.req_data = {$urandom, $urandom} & {N*DW{1'b1}};
        bus.req_data[7:0] = 8'hA5;
        bus.req_en = 4'b0001;
        exp = model_pick(bus.req_en, m_last);
        run_xfer(20, '0, 0, r);
        checks++; if (r.lat !== 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", r.lat); end
        checks++; if (r.g !== GW'(exp)) begin failures++; $display("FAIL single_grant got=%0d exp=%0d", r.g, exp); end
        checks++; if (r.d !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", r.d); end
        checks++; if (!r.stable) begin failures++; $display("FAIL single_hold got=unstable exp=stable"); end
        checks++; if (r.done1 !== 4'b0001 || r.en_after !== 1'b0 || r.busy1 !== 1'b1) begin failures++; $display("FAIL single_done got=%b/%b/%b exp=0001/0/1", r.done1, r.en_after, r.busy1); end
        checks++; if (r.done2 !== 4'b0000 || r.busy2 !== 1'b0) begin failures++; $display("FAIL single_gap_end got=%b/%b exp=0000/0", r.done2, r.busy2); end
        m_last = exp;
    endtask

    task automatic test_contention();
        xfer_t r;
        int exp;
        apply_reset();
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = DW'(8'h10 + i);
        bus.req_en = '1;
        for (int t = 0; t < 5; t++) begin
            exp = model_pick(bus.req_en, m_last);
            run_xfer(int'($urandom_range(1, 6)), '0, -1, r);
            checks++; if (r.g !== GW'(t % N) || exp != t % N) begin failures++; $display("FAIL contention_grant%0d got=%0d exp=%0d", t, r.g, t % N); end
            checks++; if (r.d !== DW'(8'h10 + t % N)) begin failures++; $display("FAIL contention_data%0d got=%h exp=%h", t, r.d, 8'h10 + t % N); end
            checks++; if (r.done1 !== N'(1 << (t % N)) || r.done2 !== '0) begin failures++; $display("FAIL contention_done%0d got=%b/%b exp=%b/0", t, r.done1, r.done2, N'(1 << (t % N))); end
            m_last = exp;
        end
        bus.req_en = '0;
    endtask

    task automatic test_wrap();
        xfer_t r;
        apply_reset();
        bus.req_data[3*DW +: DW] = 8'h33;
        bus.req_data[1*DW +: DW] = 8'h11;
        bus.req_en = 4'b1000;
        run_xfer(3, '0, 3, r);
        checks++; if (r.g !== 2'd3 || r.d !== 8'h33) begin failures++; $display("FAIL wrap_first got=%0d/%h exp=3/33", r.g, r.d); end
        m_last = 3;
        bus.req_en = 4'b0010;
        run_xfer(2, '0, 1, r);
        checks++; if (r.g !== 2'd1 || r.d !== 8'h11) begin failures++; $display("FAIL wrap_second got=%0d/%h exp=1/11", r.g, r.d); end
        m_last = 1;
        bus.req_en = 4'b1010;
        run_xfer(2, '0, 3, r);
        checks++; if (r.g !== 2'd3 || r.d !== 8'h33) begin failures++; $display("FAIL wrap_pair_first got=%0d/%h exp=3/33", r.g, r.d); end
        run_xfer(2, '0, 1, r);
        checks++; if (r.g !== 2'd1 || r.d !== 8'h11) begin failures++; $display("FAIL wrap_pair_second got=%0d/%h exp=1/11", r.g, r.d); end
        m_last = 1;
    endtask

    task automatic test_withdraw();
        xfer_t r;
        int exp;
        bus.req_data[2*DW +: DW] = 8'h5A;
        bus.req_en = 4'b0100;
        exp = model_pick(bus.req_en, m_last);
        run_xfer(6, 4'b0100, -1, r);
        checks++; if (!r.stable || r.g !== GW'(exp) || r.d !== 8'h5A) begin failures++; $display("FAIL withdraw_hold got=%0b/%0d/%h exp=1/%0d/5a", r.stable, r.g, r.d, exp); end
        checks++; if (r.done1 !== 4'b0100) begin failures++; $display("FAIL withdraw_done got=%b exp=0100", r.done1); end
        m_last = exp;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        checks++; if (bus.req_done !== '0 || bus.busy !== 1'b0 || bus.tx_en_sig !== 1'b0) begin failures++; $display("FAIL spurious_done got=%b/%b/%b exp=0000/0/0", bus.req_done, bus.busy, bus.tx_en_sig); end
        @(negedge clk);
        checks++; if (bus.req_done !== '0) begin failures++; $display("FAIL spurious_done_late got=%b exp=0000", bus.req_done); end
        bus.req_data[0 +: DW] = 8'hC1;
        bus.req_data[3*DW +: DW] = 8'hC3;
        bus.req_en = 4'b1001;
        exp = model_pick(bus.req_en, m_last);
        run_xfer(2, '0, exp, r);
        checks++; if (r.g !== GW'(exp) || r.d !== 8'hC3) begin failures++; $display("FAIL withdraw_pointer got=%0d/%h exp=%0d/c3", r.g, r.d, exp); end
        m_last = exp;
        bus.req_en = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        xfer_t r;
        int exp;
        logic [DW-1:0] exp_d;
        logic [N-1:0] add;
        apply_reset();
        for (int t = 0; t < 24; t++) begin
            add = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (add[i] && !bus.req_en[i]) begin
                    bus.req_en[i] = 1'b1;
                    bus.req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            if (bus.req_en == '0) begin
                int i;
                i = int'($urandom_range(0, N - 1));
                bus.req_en[i] = 1'b1;
                bus.req_data[i*DW +: DW] = DW'($urandom);
            end
            exp = model_pick(bus.req_en, m_last);
            exp_d = bus.req_data[exp*DW +: DW];
            run_xfer(int'($urandom_range(0, 5)), '0, exp, r);
            checks++; if (r.lat !== 1 || r.g !== GW'(exp) || r.d !== exp_d) begin failures++; $display("FAIL random%0d_pick got=lat%0d/%0d/%h exp=lat1/%0d/%h", t, r.lat, r.g, r.d, exp, exp_d); end
            checks++; if (r.done1 !== N'(1 << exp) || r.done2 !== '0 || r.busy2 !== 1'b0) begin failures++; $display("FAIL random%0d_done got=%b/%b/%b exp=%b/0/0", t, r.done1, r.done2, r.busy2, N'(1 << exp)); end
            m_last = exp;
        end
        bus.req_en = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_send();
        xfer_t r;
        int exp;
        int n;
        apply_reset();
        bus.req_data[2*DW +: DW] = 8'h5C;
        bus.req_data[1*DW +: DW] = 8'h71;
        bus.req_en = 4'b0100;
        n = 0;
        while (bus.tx_en_sig !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (bus.tx_en_sig !== 1'b1 || bus.grant !== 2'd2) begin failures++; $display("FAIL rstsend_start got=%b/%0d exp=1/2", bus.tx_en_sig, bus.grant); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.tx_en_sig !== 1'b0 || bus.busy !== 1'b0 || bus.req_done !== '0) begin failures++; $display("FAIL rstsend_ctrl got=%b/%b/%b exp=0/0/0000", bus.tx_en_sig, bus.busy, bus.req_done); end
        checks++; if (bus.grant !== '0 || bus.tx_data !== '0) begin failures++; $display("FAIL rstsend_data got=%0d/%h exp=0/00", bus.grant, bus.tx_data); end
        bus.req_en = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = N - 1;
        exp = model_pick(bus.req_en, m_last);
        run_xfer(3, '0, exp, r);
        checks++; if (r.g !== GW'(exp) || r.d !== 8'h71 || r.done1 !== N'(1 << exp)) begin failures++; $display("FAIL rstsend_after got=%0d/%h/%b exp=%0d/71/%b", r.g, r.d, r.done1, exp, N'(1 << exp)); end
        bus.req_en = '0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_withdraw();
        test_random();
        test_reset_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N independent byte sources, e.g. the rx echo path, a status reporter and a command responder.
- Arbitration is round-robin. Exactly one byte is in flight at a time.
- Drives the transmitter's tx_en_sig/tx_data/tx_done handshake on the downstream side.
- Gives each requester a mirrored en/done handshake on the upstream side.

Parameters:
- N, 4, number of requesters (2..8).
- DW, 8, data width per requester.
- GW, 2, grant index width; must equal ceil(log2(N)).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_en  input  N  per-requester request; held high with req_data stable until the matching req_done.
- req_data  input  N*DW  packed bytes; requester i uses bits [i*DW +: DW].
- req_done  output  N  one-cycle pulse to the requester whose byte finished.
- tx_en_sig  output  1  start/hold to the transmitter.
- tx_data  output  DW  byte to the transmitter; stable while tx_en_sig=1.
- tx_done  input  1  one-cycle completion pulse from the transmitter.
- busy  output  1  high in SEND and GAP.
- grant  output  GW  index of the current or last granted requester.

Behaviour:
- Reset values (asynchronous):
  - req_done=0, tx_en_sig=0, tx_data=0, busy=0, grant=0.
  - State=IDLE.
  - Internal pointer last=N-1, so requester 0 wins first.
- States: IDLE, SEND, GAP.
- IDLE:
  - If req_en!=0, select the first set bit searching last+1, last+2, ... with wrap modulo N.
  - On that edge: grant<=sel, tx_data<=req_data[sel], tx_en_sig<=1, busy<=1, go SEND.
  - Latency from req_en sampled high to tx_en_sig high is 1 cycle.
  - If req_en==0, stay in IDLE with all outputs held.
- SEND:
  - tx_en_sig and tx_data are held; req_en and req_data are not re-sampled.
  - On tx_done=1: tx_en_sig<=0, req_done[grant]<=1, last<=grant, go GAP.
- GAP: exactly one cycle.
  - req_done<=0, busy<=0, go IDLE.
  - The gap lets the requester drop or refresh req_en before the next arbitration.
  - Arbitration never occurs in GAP.
- A requester that keeps req_en high after its req_done is re-arbitrated normally. It is served again only after every other active requester.
- Boundary conditions:
  - tx_done while in IDLE or GAP is ignored; no req_done pulse.
  - Requester drops req_en while in SEND: the transfer still completes and that requester's req_done still pulses.
  - Simultaneous requests: exactly one grant; the rotating pointer guarantees service within N transfers.
  - Requests newly asserted during SEND or GAP wait for the next IDLE.
  - Only one bit of req_done is high at any time. It is high for exactly one cycle, and only in the cycle after tx_done.
  - Reset asserted mid-SEND: tx_en_sig drops immediately (asynchronously), the pointer returns to N-1, and the partial transfer is abandoned with no req_done pulse.
- Minimum cycle between successive tx_en_sig rising edges: the transmitter's own duration + 2 cycles (GAP and IDLE).

Decomposition:
- Shared package/include uart_arb_defs: state encodings ST_IDLE=2'd0, ST_SEND=2'd1, ST_GAP=2'd2, plus default N/DW.
- One sub-module, uart_rr_pick:
  - Combinational round-robin selector.
  - Inputs: req (N), last (GW).
  - Outputs: sel (GW), any (1).
  - Instantiated once in uart_tx_arbiter.

Test Plan:
- Single requester: req_en=4'b0001, req_data[7:0]=8'hA5. Expected: tx_en_sig=1 and tx_data=8'hA5 one cycle later. Model pulses tx_done after 20 cycles. Expected: req_done=4'b0001 for exactly one cycle in the next cycle, and busy low two cycles after tx_done.
- Full contention: all four req_en held high, data 8'h10..8'h13. Expected: tx_data sequence 8'h10, 8'h11, 8'h12, 8'h13, 8'h10; grant sequence 0,1,2,3,0.
- Pointer wrap: serve requester 3 (8'h33), then assert only requester 1 (8'h11). Expected: grant=1, tx_data=8'h11. Then assert requesters 1 and 3 together. Expected: 3 is served first (pointer after 1).
- Withdrawal: requester 2 drops req_en mid-SEND. Expected: tx_en_sig stays high until tx_done and req_done=4'b0100 pulses. A spurious tx_done injected in IDLE produces no req_done.
- Reset in SEND: assert rst_n=0 while tx_en_sig=1. Expected: all outputs 0 immediately. After release with req_en=4'b1010, requester 1 is granted first.
